// File: rtl/axis_sim_pkg.sv
// axis_sim_pkg -- shared constants and types for the AXI-Stream frame monitor.
// Holds the backpressure LFSR geometry (width and tap mask) and the
// frame-tracking FSM state encoding so the monitor and its LFSR agree.
package axis_sim_pkg;

    // Backpressure generator register width.
    localparam int LFSR_WIDTH = 16;

    // Fibonacci taps 16,14,13,11 expressed as a mask over state bits [15:0].
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 16'hB400;

    // Frame tracking: IDLE means no beat of the current frame accepted yet.
    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_IN_FRAME = 1'b1
    } frame_state_t;

endpackage

// File: rtl/axis_lfsr.sv
// axis_lfsr -- free-running Fibonacci LFSR used as a pseudo-random
// backpressure source. Shifts left every cycle, feeding the parity of the
// tapped bits into bit 0; q is bit 0 of the state. Reset is synchronous,
// active-high, and reloads SEED (which must be nonzero).
module axis_lfsr
    import axis_sim_pkg::*;
#(
    parameter int               WIDTH = LFSR_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'hACE1)
) (
    input  logic clk,
    input  logic reset,
    output logic q
);

    logic [WIDTH-1:0] r_state;
    logic             w_feedback;

    assign w_feedback = ^(r_state & WIDTH'(LFSR_TAPS));

    // Advance the shift register every cycle; reload the seed on reset.
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SEED;
        end else begin
            r_state <= {r_state[WIDTH-2:0], w_feedback};
        end
    end

    assign q = r_state[0];

endmodule

// File: rtl/axis_frame_monitor.sv
// axis_frame_monitor -- AXI-Stream sink that measures frames and checks data.
// Accepts beats with a registered tready (constant 1, or LFSR-driven when
// cfg_bp_en is set), counts beats and bytes per frame with saturation,
// reports each completed frame one cycle after its tlast beat, optionally
// checks the expected frame length and an incrementing-data pattern.
// Optional trace: define AXIS_FRAME_MONITOR_DISPLAY_EN to $display frame
// lengths and data-check mismatches (simulation only; ports unaffected).
module axis_frame_monitor
    import axis_sim_pkg::*;
#(
    parameter int                    DATA_WIDTH = 64,
    parameter int                    CNT_WIDTH  = 32,
    parameter logic [LFSR_WIDTH-1:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                    s_axis_aclk,
    input  logic                    s_axis_areset,
    input  logic                    s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    input  logic                    cfg_bp_en,
    input  logic                    cfg_chk_en,
    input  logic [CNT_WIDTH-1:0]    cfg_exp_len,
    output logic                    frame_done,
    output logic [CNT_WIDTH-1:0]    last_beats,
    output logic [CNT_WIDTH-1:0]    last_bytes,
    output logic [CNT_WIDTH-1:0]    frame_cnt,
    output logic [CNT_WIDTH-1:0]    len_err_cnt,
    output logic [CNT_WIDTH-1:0]    data_err_cnt
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int POP_WIDTH  = $clog2(STRB_WIDTH + 1);
    // One spare bit above the wider operand so a saturating add can see overflow.
    localparam int SUM_WIDTH  = ((CNT_WIDTH > POP_WIDTH) ? CNT_WIDTH : POP_WIDTH) + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Handshake and backpressure
    logic                  r_tready;
    logic                  w_lfsr_q;
    logic                  w_beat;

    // Frame FSM
    frame_state_t          r_state;
    frame_state_t          w_state_next;
    logic                  w_first_beat;

    // Per-frame accumulation
    logic [POP_WIDTH-1:0]  w_strb_pop;
    logic [SUM_WIDTH-1:0]  w_beat_sum;
    logic [SUM_WIDTH-1:0]  w_byte_sum;
    logic [CNT_WIDTH-1:0]  w_beat_total;
    logic [CNT_WIDTH-1:0]  w_byte_total;
    logic [CNT_WIDTH-1:0]  r_beat_acc;
    logic [CNT_WIDTH-1:0]  r_byte_acc;

    // Data and length checks
    logic [DATA_WIDTH-1:0] r_prev_data;
    logic [DATA_WIDTH-1:0] w_exp_data;
    logic                  w_data_err;
    logic                  w_len_err;
    logic                  w_frame_end;

    // Reported statistics
    logic                  r_frame_done;
    logic [CNT_WIDTH-1:0]  r_last_beats;
    logic [CNT_WIDTH-1:0]  r_last_bytes;
    logic [CNT_WIDTH-1:0]  r_frame_cnt;
    logic [CNT_WIDTH-1:0]  r_len_err_cnt;
    logic [CNT_WIDTH-1:0]  r_data_err_cnt;

    // ------------------------------------------------------------------
    // Backpressure source
    // ------------------------------------------------------------------
    axis_lfsr #(
        .WIDTH (LFSR_WIDTH),
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk   (s_axis_aclk),
        .reset (s_axis_areset),
        .q     (w_lfsr_q)
    );

    // Registered ready: low through reset and the cycle after, then always-on or LFSR bit 0.
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            r_tready <= 1'b0;
        end else begin
            r_tready <= cfg_bp_en ? w_lfsr_q : 1'b1;
        end
    end

    assign w_beat      = s_axis_tvalid & r_tready;
    assign w_frame_end = w_beat & s_axis_tlast;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------

    // Frame state register; a reset mid-frame drops the partial frame.
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state only moves on accepted beats; stalls leave it untouched.
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_first_beat = 1'b0;
        if (r_state == ST_IDLE) begin
            w_first_beat = 1'b1;
        end
        if (w_beat) begin
            w_state_next = s_axis_tlast ? ST_IDLE : ST_IN_FRAME;
        end
    end

    // ------------------------------------------------------------------
    // Per-frame beat/byte totals including the current beat
    // ------------------------------------------------------------------
    assign w_strb_pop = POP_WIDTH'($countones(s_axis_tstrb));

    // Saturating running totals; the first beat of a frame restarts from zero.
    always_comb begin
        w_beat_sum   = '0;
        w_byte_sum   = '0;
        w_beat_total = '0;
        w_byte_total = '0;
        if (w_first_beat) begin
            w_beat_sum = SUM_WIDTH'(1);
            w_byte_sum = SUM_WIDTH'(w_strb_pop);
        end else begin
            w_beat_sum = SUM_WIDTH'(r_beat_acc) + SUM_WIDTH'(1);
            w_byte_sum = SUM_WIDTH'(r_byte_acc) + SUM_WIDTH'(w_strb_pop);
        end
        w_beat_total = (w_beat_sum > SUM_WIDTH'(CNT_MAX)) ? CNT_MAX : w_beat_sum[CNT_WIDTH-1:0];
        w_byte_total = (w_byte_sum > SUM_WIDTH'(CNT_MAX)) ? CNT_MAX : w_byte_sum[CNT_WIDTH-1:0];
    end

    // ------------------------------------------------------------------
    // Checks
    // ------------------------------------------------------------------
    assign w_exp_data = r_prev_data + DATA_WIDTH'(1);

    // The first beat of a frame seeds the reference and is never an error.
    assign w_data_err = w_beat & cfg_chk_en & ~w_first_beat & (s_axis_tdata != w_exp_data);

    // Length is judged against cfg_exp_len as seen on the tlast beat.
    assign w_len_err  = w_frame_end & (cfg_exp_len != '0) & (w_beat_total != cfg_exp_len);

    // Reference word for the data check follows received data, not the expected sequence.
    // NOTE: pure datapath register without reset; it is only read after a beat of the current frame wrote it.
    always_ff @(posedge s_axis_aclk) begin
        if (w_beat) begin
            r_prev_data <= s_axis_tdata;
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------

    // Accumulate per-frame totals and publish them, with error counts, one cycle after tlast.
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            r_beat_acc     <= '0;
            r_byte_acc     <= '0;
            r_frame_done   <= 1'b0;
            r_last_beats   <= '0;
            r_last_bytes   <= '0;
            r_frame_cnt    <= '0;
            r_len_err_cnt  <= '0;
            r_data_err_cnt <= '0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_beat) begin
                r_beat_acc <= w_beat_total;
                r_byte_acc <= w_byte_total;
            end
            if (w_frame_end) begin
                r_last_beats <= w_beat_total;
                r_last_bytes <= w_byte_total;
                r_frame_cnt  <= r_frame_cnt + CNT_WIDTH'(1);
            end
            if (w_len_err && (r_len_err_cnt != CNT_MAX)) begin
                r_len_err_cnt <= r_len_err_cnt + CNT_WIDTH'(1);
            end
            if (w_data_err && (r_data_err_cnt != CNT_MAX)) begin
                r_data_err_cnt <= r_data_err_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign s_axis_tready = r_tready;
    assign frame_done    = r_frame_done;
    assign last_beats    = r_last_beats;
    assign last_bytes    = r_last_bytes;
    assign frame_cnt     = r_frame_cnt;
    assign len_err_cnt   = r_len_err_cnt;
    assign data_err_cnt  = r_data_err_cnt;

`ifdef AXIS_FRAME_MONITOR_DISPLAY_EN
    // Simulation trace of each reported frame and each data-check mismatch.
    always_ff @(posedge s_axis_aclk) begin
        if (r_frame_done) begin
            $display("frame length,%0d,%0d", r_last_beats, r_last_bytes);
        end
        if (w_data_err && !s_axis_areset) begin
            $display("data error,%0d,%0d", w_exp_data, s_axis_tdata);
        end
    end
`else
    // Trace disabled: synthesisable build with no simulation output.
`endif

endmodule

// File: tb/tb_axis_frame_monitor.sv
// tb_axis_frame_monitor -- directed bench for axis_frame_monitor.
// Two instances share one stimulus: dut_a (32-bit data, 32-bit counters)
// and dut_b (32-bit data, 4-bit counters, to exercise saturation/wrap).
// A frame-level model predicts every output each cycle; literal checks pin
// the scenario results.
module tb_axis_frame_monitor;

    localparam int          DW   = 32;
    localparam int          SW   = DW / 8;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic [SW-1:0] tstrb;
    logic          tlast;
    logic          bp_en;
    logic          chk_en;
    logic [31:0]   exp_len;

    logic        tready_a, done_a;
    logic [31:0] lb_a, lby_a, fc_a, le_a, de_a;
    logic        tready_b, done_b;
    logic [3:0]  lb_b, lby_b, fc_b, le_b, de_b;

    axis_frame_monitor #(.DATA_WIDTH(DW), .CNT_WIDTH(32), .LFSR_SEED(SEED)) dut_a (
        .s_axis_aclk(clk), .s_axis_areset(rst),
        .s_axis_tvalid(tvalid), .s_axis_tdata(tdata), .s_axis_tstrb(tstrb),
        .s_axis_tlast(tlast), .s_axis_tready(tready_a),
        .cfg_bp_en(bp_en), .cfg_chk_en(chk_en), .cfg_exp_len(exp_len),
        .frame_done(done_a), .last_beats(lb_a), .last_bytes(lby_a),
        .frame_cnt(fc_a), .len_err_cnt(le_a), .data_err_cnt(de_a)
    );

    axis_frame_monitor #(.DATA_WIDTH(DW), .CNT_WIDTH(4), .LFSR_SEED(SEED)) dut_b (
        .s_axis_aclk(clk), .s_axis_areset(rst),
        .s_axis_tvalid(tvalid), .s_axis_tdata(tdata), .s_axis_tstrb(tstrb),
        .s_axis_tlast(tlast), .s_axis_tready(tready_b),
        .cfg_bp_en(bp_en), .cfg_chk_en(chk_en), .cfg_exp_len(exp_len[3:0]),
        .frame_done(done_b), .last_beats(lb_b), .last_bytes(lby_b),
        .frame_cnt(fc_b), .len_err_cnt(le_b), .data_err_cnt(de_b)
    );

    // ---------------- checking ----------------
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint mn(input longint a, input longint b);
        return (a < b) ? a : b;
    endfunction

    // ---------------- behavioural model ----------------
    // Raw (unbounded) event counts; each instance's outputs are derived by
    // clamping or wrapping these to its counter width.
    longint      m_max [2] = '{64'hFFFF_FFFF, 64'd15};
    bit          started   = 0;
    logic [15:0] m_lfsr;
    bit          m_ready;
    bit          m_done;
    bit          m_in_frame;
    logic [31:0] m_prev;
    longint      m_cur_beats, m_cur_bytes;
    longint      m_last_beats, m_last_bytes;
    longint      m_frames, m_data_errs;
    longint      m_len_errs [2];

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                started      = 1;
                m_lfsr       = SEED;
                m_ready      = 0;
                m_done       = 0;
                m_in_frame   = 0;
                m_prev       = '0;
                m_cur_beats  = 0;
                m_cur_bytes  = 0;
                m_last_beats = 0;
                m_last_bytes = 0;
                m_frames     = 0;
                m_data_errs  = 0;
                m_len_errs   = '{0, 0};
            end else begin
                bit          beat;
                logic [31:0] want;
                int unsigned s, fb;
                beat   = tvalid && m_ready;
                m_done = 0;
                if (beat) begin
                    want = m_prev + 32'd1;
                    if (chk_en && m_in_frame && (tdata != want)) m_data_errs++;
                    m_prev      = tdata;
                    m_cur_beats = m_in_frame ? m_cur_beats + 1 : 1;
                    m_cur_bytes = (m_in_frame ? m_cur_bytes : 0) + $countones(tstrb);
                    if (tlast) begin
                        m_done       = 1;
                        m_last_beats = m_cur_beats;
                        m_last_bytes = m_cur_bytes;
                        m_frames++;
                        for (int k = 0; k < 2; k++) begin
                            longint el;
                            el = longint'(exp_len) & m_max[k];
                            if (el != 0 && mn(m_cur_beats, m_max[k]) != el) m_len_errs[k]++;
                        end
                        m_in_frame = 0;
                    end else begin
                        m_in_frame = 1;
                    end
                end
                // ready for the next cycle comes from the LFSR value before it advances
                m_ready = bp_en ? m_lfsr[0] : 1'b1;
                s       = m_lfsr;
                fb      = ((s >> 15) ^ (s >> 13) ^ (s >> 12) ^ (s >> 10)) & 1;
                m_lfsr  = 16'((s << 1) | fb);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int     done_seen = 0;
    int     toggles   = 0;
    longint beat_sum  = 0;
    int     lb_hist[$];
    logic   prev_tready = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("tready_a", tready_a, m_ready);
                check("tready_b", tready_b, m_ready);
                check("done_a",   done_a,   m_done);
                check("done_b",   done_b,   m_done);
                check("lb_a",     lb_a,     mn(m_last_beats, m_max[0]));
                check("lb_b",     lb_b,     mn(m_last_beats, m_max[1]));
                check("lby_a",    lby_a,    mn(m_last_bytes, m_max[0]));
                check("lby_b",    lby_b,    mn(m_last_bytes, m_max[1]));
                check("fc_a",     fc_a,     m_frames % (m_max[0] + 1));
                check("fc_b",     fc_b,     m_frames % (m_max[1] + 1));
                check("le_a",     le_a,     mn(m_len_errs[0], m_max[0]));
                check("le_b",     le_b,     mn(m_len_errs[1], m_max[1]));
                check("de_a",     de_a,     mn(m_data_errs, m_max[0]));
                check("de_b",     de_b,     mn(m_data_errs, m_max[1]));
                if (done_a === 1'b1) begin
                    done_seen++;
                    lb_hist.push_back(int'(lb_a));
                    beat_sum += longint'(lb_a);
                end
                if (tready_a !== prev_tready) toggles++;
                prev_tready = tready_a;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // All helpers start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        tvalid = 1'b0;
        tlast  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        int   waited = 0;
        bit   ok     = 0;
        logic rdy;
        tvalid = 1'b1;
        tdata  = d;
        tstrb  = s;
        tlast  = l;
        while (!ok && waited < 200) begin
            rdy = tready_a;
            @(posedge clk);
            #1;
            ok = (rdy === 1'b1);
            waited++;
        end
        if (!ok) check("beat_accept", ok, 1'b1);
    endtask

    task automatic send_frame(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) send_beat(start + 32'(i), 4'hF, (i == n - 1));
    endtask

    // Safety net against a hung handshake.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int     d0, t0;
        longint s0;
        rst = 1'b1; tvalid = 1'b0; tdata = '0; tstrb = '0; tlast = 1'b0;
        bp_en = 1'b0; chk_en = 1'b0; exp_len = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state and the forced-low first cycle
        check("rst_tready", tready_a, 1'b0);
        check("rst_done",   done_a,   1'b0);
        check("rst_fc",     fc_a,     32'd0);
        check("rst_lb",     lb_a,     32'd0);
        check("rst_errs",   {le_a, de_a}, 64'd0);
        @(posedge clk);
        #1;
        check("ready_on", tready_a, 1'b1);

        // Frames of 4, 1, 7 beats, incrementing data, no backpressure
        chk_en = 1'b1;
        send_frame(32'd0, 4);
        send_frame(32'd4, 1);
        send_frame(32'd5, 7);
        idle(3);
        check("done_x3",    done_seen,  3);
        check("lb_first",   lb_hist[0], 4);
        check("lb_second",  lb_hist[1], 1);
        check("lb_third",   lb_hist[2], 7);
        check("fc_3",       fc_a,       32'd3);
        check("lby_28",     lby_a,      32'd28);
        check("errs_0",     {le_a, de_a}, 64'd0);
        check("model_lb_7", m_last_beats, 64'd7);

        // Expected length 8: an 8-beat frame passes, a 6-beat frame errors with its frame_done
        exp_len = 32'd8;
        send_frame(32'd100, 8);
        idle(2);
        check("len_ok_8", le_a, 32'd0);
        send_frame(32'd200, 6);
        check("len_err_done", done_a, 1'b1);
        check("len_err_1",    le_a,   32'd1);
        idle(2);
        exp_len = 32'd0;
        check("fc_b_5", fc_b, 4'd5);

        // Corrupt word 99 in 10,11,99,13,14 costs two errors; a fresh seed costs none
        send_beat(32'd10, 4'hF, 1'b0);
        send_beat(32'd11, 4'hF, 1'b0);
        send_beat(32'd99, 4'hF, 1'b0);
        send_beat(32'd13, 4'hF, 1'b0);
        send_beat(32'd14, 4'hF, 1'b1);
        idle(2);
        check("data_err_2", de_a, 32'd2);
        send_frame(32'd500, 3);
        idle(2);
        check("seed_no_err", de_a, 32'd2);
        check("fc_7",        fc_a, 32'd7);

        // Backpressure on: 1000 beats in 100 frames, tvalid held throughout
        bp_en = 1'b1;
        s0 = beat_sum;
        t0 = toggles;
        for (int f = 0; f < 100; f++) send_frame(32'(1000 + 10 * f), 10);
        idle(3);
        bp_en = 1'b0;
        idle(2);
        check("bp_beats",   beat_sum - s0, 64'd1000);
        check("bp_toggles", (toggles - t0) > 20, 1'b1);
        check("bp_de",      de_a, 32'd2);
        check("bp_fc",      fc_a, 32'd107);

        // Partial strobes: F,F,3 -> 10 bytes
        send_beat(32'd0, 4'hF, 1'b0);
        send_beat(32'd1, 4'hF, 1'b0);
        send_beat(32'd2, 4'h3, 1'b1);
        idle(2);
        check("lby_10", lby_a, 32'd10);
        check("lb_3",   lb_a,  32'd3);

        // Reset after beat 2 of a 5-beat frame discards it silently
        d0 = done_seen;
        send_beat(32'd0, 4'hF, 1'b0);
        send_beat(32'd1, 4'hF, 1'b0);
        tvalid = 1'b0;
        rst    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_outs", {lb_a, lby_a, fc_a, le_a, de_a}, 64'd0);
        check("mid_rst_rdy",  tready_a, 1'b0);
        idle(2);
        check("mid_rst_nodone", done_seen, d0);
        send_frame(32'd50, 5);
        idle(2);
        check("post_rst_fc", fc_a, 32'd1);
        check("post_rst_lb", lb_a, 32'd5);

        // 20-beat frame: 4-bit counters saturate at 15, no length check
        send_frame(32'd0, 20);
        idle(2);
        check("sat_lb_b",   lb_b,  4'd15);
        check("sat_lby_b",  lby_b, 4'd15);
        check("sat_le_b",   le_b,  4'd0);
        check("full_lb_a",  lb_a,  32'd20);
        check("fc_b_2",     fc_b,  4'd2);
        check("model_lb20", m_last_beats, 64'd20);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
